// File: rtl/ads124x_ts_framer_pkg.sv
// Shared widths, beat encodings and the FIFO entry layout for the ADS124x timestamp framer.
package ads124x_pkg;

    localparam int SAMPLE_W = 32;
    localparam int TS_W     = 32;
    localparam int ENTRY_W  = 96;

    typedef enum logic [1:0] {
        BEAT_SEC  = 2'd0,
        BEAT_SUB  = 2'd1,
        BEAT_DATA = 2'd2
    } beat_e;

    typedef struct packed {
        logic [TS_W-1:0]     sec;
        logic [TS_W-1:0]     subsec;
        logic [SAMPLE_W-1:0] sample;
    } entry_t;

endpackage

// File: rtl/ads124x_ts_framer_if.sv
// AXI-Stream style beat bundle used for both the sample input and the packet output.
interface ads124x_ts_framer_if #(
    parameter int W = 32
) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/ads124x_ts_framer_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty/level and wrap-bit pointers.
module ads124x_ts_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 96
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_pop,
    output logic [W-1:0]             o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  ONE      = (AW+1)'(1);
    localparam logic [AW:0]  LVL_FULL = (AW+1)'(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr, r_rptr, r_level;
    logic         r_full, r_empty;
    logic         w_wr, w_rd;
    logic [AW:0]  w_level_nxt;

    // Guarded by the registered flags, so a pop at full never frees room for a same-cycle push.
    assign w_wr = i_push & ~r_full;
    assign w_rd = i_pop  & ~r_empty;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr, w_rd})
            2'b10:   w_level_nxt = r_level + ONE;
            2'b01:   w_level_nxt = r_level - ONE;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_wr) r_wptr <= r_wptr + ONE;
            if (w_rd) r_rptr <= r_rptr + ONE;
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_FULL);
            r_empty <= (w_level_nxt == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_level = r_level;

endmodule

// File: rtl/ads124x_ts_framer.sv
// Tags each ADS124x conversion with a PPS-disciplined {sec, subsec} stamp, buffers it and
// emits it as a 3-beat packet (sec, subsec, sample+tlast). Input never stalls; overflow is counted.
module ads124x_ts_framer
    import ads124x_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DROP_W     = 16
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          enable,
    input  logic                          pps,
    ads124x_ts_framer_if.slave            s_axis,
    ads124x_ts_framer_if.master           m_axis,
    output logic [DROP_W-1:0]             drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    logic              r_sync1, r_pps_s, r_pps_d;
    logic [TS_W-1:0]   r_sec_cnt, r_sub_cnt;
    logic              r_s_ready;
    logic [DROP_W-1:0] r_drop;
    beat_e             r_beat, w_beat_nxt;

    logic              w_pps_edge, w_accept, w_push, w_drop, w_pop, w_hs;
    logic              w_full, w_empty;
    entry_t            w_wentry, w_head;
    logic [31:0]       w_tdata;
    logic              w_tlast;

    assign w_pps_edge = r_pps_s & ~r_pps_d;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_sync1   <= 1'b0;
            r_pps_s   <= 1'b0;
            r_pps_d   <= 1'b0;
            r_sec_cnt <= '0;
            r_sub_cnt <= '0;
        end else begin
            r_sync1 <= pps;
            r_pps_s <= r_sync1;
            r_pps_d <= r_pps_s;
            if (w_pps_edge) begin
                r_sec_cnt <= r_sec_cnt + 32'd1;
                r_sub_cnt <= '0;
            end else if (r_sub_cnt != '1) begin
                r_sub_cnt <= r_sub_cnt + 32'd1;
            end
        end
    end

    // Stamp uses the counters as they stand during the accept cycle, before any PPS update.
    assign w_accept = s_axis.tvalid & r_s_ready;
    assign w_push   = w_accept & enable & ~w_full;
    assign w_drop   = w_accept & enable &  w_full;
    assign w_wentry = '{sec: r_sec_cnt, subsec: r_sub_cnt, sample: s_axis.tdata};

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_s_ready <= 1'b0;
            r_drop    <= '0;
        end else begin
            r_s_ready <= 1'b1;
            if (w_drop && r_drop != '1) r_drop <= r_drop + DROP_W'(1);
        end
    end

    ads124x_ts_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .i_clk   (aclk),
        .i_rst   (areset),
        .i_push  (w_push),
        .i_wdata (w_wentry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign w_hs  = ~w_empty & m_axis.tready;
    assign w_pop = w_hs & (r_beat == BEAT_DATA);

    always_ff @(posedge aclk) begin
        if (areset) r_beat <= BEAT_SEC;
        else        r_beat <= w_beat_nxt;
    end

    // The head entry stays put until its last beat is taken, which keeps stalled beats stable.
    always_comb begin
        w_beat_nxt = r_beat;
        w_tdata    = '0;
        w_tlast    = 1'b0;
        if (!w_empty) begin
            case (r_beat)
                BEAT_SEC:  w_tdata = w_head.sec;
                BEAT_SUB:  w_tdata = w_head.subsec;
                BEAT_DATA: begin
                    w_tdata = w_head.sample;
                    w_tlast = 1'b1;
                end
                default:   ;
            endcase
        end
        if (w_hs) begin
            case (r_beat)
                BEAT_SEC: w_beat_nxt = BEAT_SUB;
                BEAT_SUB: w_beat_nxt = BEAT_DATA;
                default:  w_beat_nxt = BEAT_SEC;
            endcase
        end
    end

    assign s_axis.tready = r_s_ready;
    assign m_axis.tvalid = ~w_empty;
    assign m_axis.tdata  = w_tdata;
    assign m_axis.tlast  = w_tlast;
    assign drop_count    = r_drop;

endmodule

// File: tb/tb_ads124x_ts_framer.sv
// Self-checking bench: queue-based reference model plus directed timestamp/overflow/reset cases.
module tb_ads124x_ts_framer;
    import ads124x_pkg::*;

    localparam int DEPTH  = 16;
    localparam int DROP_W = 4;
    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int DMAX   = (1 << DROP_W) - 1;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic              enable = 1'b0;
    logic              pps = 1'b0;
    logic [DROP_W-1:0] drop_count;
    logic [LW-1:0]     fifo_level;

    ads124x_ts_framer_if #(.W(32)) s_axis ();
    ads124x_ts_framer_if #(.W(32)) m_axis ();

    ads124x_ts_framer #(.FIFO_DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .enable     (enable),
        .pps        (pps),
        .s_axis     (s_axis),
        .m_axis     (m_axis),
        .drop_count (drop_count),
        .fifo_level (fifo_level)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] data;
        bit          en;
        int          gap;
        int          exp_pkt;
    } vec_t;

    int          checks = 0, errors = 0;
    bit          chk_en = 0;
    int          rdy_pct = 100;
    int          cyc = 0;
    entry_t      ent_q[$];
    int          mbeat = 0;
    logic [31:0] m_sec = 0, m_sub = 0;
    bit          m_srdy = 0;
    int          m_drop = 0;
    int          pend_q[$];
    bit          prev_pps = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = 0;
    logic        prev_last = 0;
    logic [31:0] got_q[$];
    int          tlast_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_beat();
        entry_t e = ent_q[0];
        case (mbeat)
            0:       return e.sec;
            1:       return e.subsec;
            default: return e.sample;
        endcase
    endfunction

    // One clock: compare visible state to the model, pick tready, advance the model across the edge.
    task automatic tick();
        bit hs, full;
        if (chk_en) begin
            check("tvalid", m_axis.tvalid, ent_q.size() != 0);
            check("level", fifo_level, ent_q.size());
            check("drop_count", drop_count, m_drop);
            check("s_tready", s_axis.tready, m_srdy);
            if (prev_stall) begin
                check("stall_tdata", m_axis.tdata, prev_data);
                check("stall_tlast", m_axis.tlast, prev_last);
            end
        end
        m_axis.tready = ($urandom_range(99) < rdy_pct);
        hs = (ent_q.size() != 0) && m_axis.tready;
        if (hs && chk_en) begin
            check("beat_tdata", m_axis.tdata, exp_beat());
            check("beat_tlast", m_axis.tlast, mbeat == 2);
            got_q.push_back(m_axis.tdata);
            if (m_axis.tlast) tlast_cnt++;
        end
        prev_stall = m_axis.tvalid && !m_axis.tready && !areset;
        prev_data  = m_axis.tdata;
        prev_last  = m_axis.tlast;
        full = ent_q.size() >= DEPTH;
        if (areset) begin
            ent_q.delete(); pend_q.delete();
            mbeat = 0; m_sec = 0; m_sub = 0; m_drop = 0; m_srdy = 0;
        end else begin
            if (m_srdy && s_axis.tvalid && enable) begin
                if (full) begin
                    if (m_drop < DMAX) m_drop++;
                end else begin
                    ent_q.push_back('{sec: m_sec, subsec: m_sub, sample: s_axis.tdata});
                end
            end
            if (hs) begin
                if (mbeat == 2) begin
                    void'(ent_q.pop_front());
                    mbeat = 0;
                end else mbeat++;
            end
            if (pps && !prev_pps) pend_q.push_back(cyc + 2);
            if (pend_q.size() != 0 && pend_q[0] == cyc) begin
                void'(pend_q.pop_front());
                m_sec = m_sec + 1;
                m_sub = 0;
            end else if (m_sub != 32'hFFFF_FFFF) m_sub = m_sub + 1;
            m_srdy = 1;
        end
        prev_pps = areset ? 1'b0 : pps;
        @(posedge aclk);
        cyc++;
        @(negedge aclk);
    endtask

    task automatic push(input logic [31:0] d);
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = d;
        tick();
        s_axis.tvalid = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (3) tick();
        areset = 1'b0;
    endtask

    vec_t tbl[6];

    initial begin
        int n0;
        logic [31:0] sub_old;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tlast  = 1'b0;
        m_axis.tready = 1'b1;

        tbl[0] = '{32'h0100_0001, 1'b1, 5, 1};
        tbl[1] = '{32'hFF80_0000, 1'b1, 5, 1};
        tbl[2] = '{32'h02AB_CDEF, 1'b0, 5, 0};
        tbl[3] = '{32'h0000_0000, 1'b1, 5, 1};
        tbl[4] = '{32'h037F_FFFF, 1'b0, 5, 0};
        tbl[5] = '{32'hA5A5_A5A5, 1'b1, 5, 1};

        do_reset();
        chk_en = 1;
        check("rst_tvalid", m_axis.tvalid, 0);
        check("rst_tdata", m_axis.tdata, 0);
        check("rst_tlast", m_axis.tlast, 0);
        check("rst_level", fifo_level, 0);
        check("rst_drop", drop_count, 0);
        tick();
        enable = 1'b1;

        for (int i = 0; i < 6; i++) begin
            n0 = tlast_cnt;
            enable = tbl[i].en;
            push(tbl[i].data);
            enable = 1'b1;
            repeat (tbl[i].gap) tick();
            check("tbl_pkts", tlast_cnt - n0, tbl[i].exp_pkt);
            if (tbl[i].exp_pkt != 0 && got_q.size() != 0)
                check("tbl_sample", got_q[got_q.size()-1], tbl[i].data);
        end

        // PPS edge then 1000 cycles: packet reads sec=1, subsec=998 after the sync delay
        do_reset();
        pps = 1'b1;
        tick();
        for (int i = 0; i < 1000; i++) begin
            if (i == 4) pps = 1'b0;
            tick();
        end
        got_q.delete();
        push(32'h0312_3456);
        repeat (5) tick();
        check("ts_beats", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("ts_sec", got_q[0], 32'd1);
            check("ts_sub", got_q[1], 32'd998);
            check("ts_sample", got_q[2], 32'h0312_3456);
        end

        // PPS counter update lands on the same edge as the first accept
        repeat (20) tick();
        got_q.delete();
        pps = 1'b1;
        tick();
        tick();
        push(32'h0400_0001);
        pps = 1'b0;
        push(32'h0400_0002);
        repeat (8) tick();
        check("same_beats", got_q.size(), 6);
        if (got_q.size() == 6) begin
            sub_old = got_q[1];
            check("same_sec_old", got_q[0], 32'd1);
            check("same_sub_old", sub_old > 32'd20, 1);
            check("same_sec_new", got_q[3], 32'd2);
            check("same_sub_new", got_q[4], 32'd0);
        end

        // Overflow: 20 pushes into a stalled 16-deep FIFO
        rdy_pct = 0;
        for (int i = 0; i < 20; i++) push(32'h0500_0000 + i);
        tick();
        check("ovf_level", fifo_level, 16);
        check("ovf_drop", drop_count, 4);
        got_q.delete();
        tlast_cnt = 0;
        rdy_pct = 100;
        repeat (60) tick();
        check("ovf_beats", got_q.size(), 48);
        check("ovf_tlast", tlast_cnt, 16);

        rdy_pct = 0;
        for (int i = 0; i < 30; i++) push(32'h0600_0000 + i);
        tick();
        check("drop_sat", drop_count, DMAX);
        rdy_pct = 100;
        repeat (60) tick();

        // Random traffic with 30% downstream ready
        rdy_pct = 30;
        for (int i = 0; i < 600; i++) begin
            pps = ($urandom_range(149) == 0);
            enable = ($urandom_range(9) != 0);
            s_axis.tvalid = ($urandom_range(11) == 0);
            s_axis.tdata  = $urandom;
            tick();
        end
        s_axis.tvalid = 1'b0;
        pps = 1'b0;
        enable = 1'b1;
        rdy_pct = 100;
        repeat (80) tick();
        check("rand_drained", fifo_level, 0);

        // Mid-packet reset with input still valid
        rdy_pct = 0;
        push(32'h0700_0001);
        rdy_pct = 100;
        tick();
        rdy_pct = 0;
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = 32'h0700_0002;
        do_reset();
        check("mid_rst_tvalid", m_axis.tvalid, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_drop", drop_count, 0);
        check("mid_rst_tdata", m_axis.tdata, 0);
        check("mid_rst_s_ready", s_axis.tready, 0);
        s_axis.tvalid = 1'b0;
        rdy_pct = 100;
        repeat (6) tick();
        check("mid_rst_empty", fifo_level, 0);

        // Subsecond saturation without PPS
        force dut.r_sub_cnt = 32'hFFFF_FFFD;
        tick();
        release dut.r_sub_cnt;
        repeat (6) tick();
        m_sub = 32'hFFFF_FFFF;
        got_q.delete();
        push(32'h08AA_5555);
        repeat (5) tick();
        check("sat_beats", got_q.size(), 3);
        if (got_q.size() == 3) check("sat_subsec", got_q[1], 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
